// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready pipeline register with stall (en), flush
// and bubble squeezing. Each stage holds a valid bit and a payload; the last
// stage drives out_valid/out_data straight from its flops.
// Optional build macro PIPE_REG_PERF_EN adds the stall_cnt/flush_cnt
// performance counters and their output ports.
module pipe_reg #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef PIPE_REG_PERF_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt
`endif
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [DEPTH-1:0] mv_s;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];

   // Move enables: a stage may advance when the pipe is enabled and some
   // stage at or after it is empty, or the output is being consumed. This is
   // the unrolled form of mv[k] = en & (!v[k] | mv[k+1]).
   always_comb begin : move_calc
      logic hole;
      hole = out_ready;
      mv_s = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         hole    = hole | ~v_q[k];
         mv_s[k] = en & hole;
      end
   end

   // Next-state for valid bits and payloads; flush drops valids, payloads hold.
   always_comb begin
      v_d = v_q;
      for (int k = 0; k < DEPTH; k++) begin
         d_d[k] = d_q[k];
      end
      if (flush) begin
         v_d = '0;
      end else begin
         if (mv_s[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
               d_d[0] = in_data;
            end else begin
               d_d[0] = d_q[0];
            end
         end else begin
            v_d[0] = v_q[0];
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (mv_s[k]) begin
               v_d[k] = v_q[k-1];
               if (v_q[k-1]) begin
                  d_d[k] = d_q[k-1];
               end else begin
                  d_d[k] = d_q[k];
               end
            end else begin
               v_d[k] = v_q[k];
            end
         end
      end
   end

   // Stage registers with synchronous reset clearing valids and payloads.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= d_d[k];
         end
      end
   end

   assign in_ready  = mv_s[0];
   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];

`ifdef PIPE_REG_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] flush_cnt_q;
   logic [31:0] flush_cnt_d;

   // Counter increments: stalled output or disabled pipe, and flush cycles.
   always_comb begin
      if ((v_q[DEPTH-1] & ~out_ready) | ~en) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (flush) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Counter registers, cleared by reset, wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed self-checking bench for pipe_reg: three instances (DEPTH 1, 2, 3)
// share all inputs; each scenario checks only the instance it targets.
module tb_pipe_reg;

   logic        clk = 1'b0;
   logic        reset, en, flush, in_valid, out_ready;
   logic [63:0] in_data;
   logic        rdy1, rdy2, rdy3;
   logic        ov1, ov2, ov3;
   logic [63:0] od1, od2, od3;
`ifdef PIPE_REG_PERF_EN
   logic [31:0] sc1, sc2, sc3, fc1, fc2, fc3;
   logic [31:0] sc_base;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_reg #(.WIDTH(64), .DEPTH(1)) u1 (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
      .out_valid(ov1), .out_data(od1), .out_ready(out_ready)
`ifdef PIPE_REG_PERF_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );

   pipe_reg #(.WIDTH(64), .DEPTH(2)) u2 (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
      .out_valid(ov2), .out_data(od2), .out_ready(out_ready)
`ifdef PIPE_REG_PERF_EN
      , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
   );

   pipe_reg #(.WIDTH(64), .DEPTH(3)) u3 (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy3),
      .out_valid(ov3), .out_data(od3), .out_ready(out_ready)
`ifdef PIPE_REG_PERF_EN
      , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock edge, then settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; en = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_data = 64'd0; out_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      // reset state
      check("rst_ov1", {63'd0, ov1}, 64'd0);
      check("rst_od1", od1, 64'd0);
      check("rst_ov3", {63'd0, ov3}, 64'd0);
      check("rst_od3", od3, 64'd0);
`ifdef PIPE_REG_PERF_EN
      check("rst_sc3", {32'd0, sc3}, 64'd0);
      check("rst_fc3", {32'd0, fc3}, 64'd0);
`endif

      // DEPTH=1 single transfer, latency 1
      in_valid = 1'b1; in_data = 64'h0000_3000_2402_0001; out_ready = 1'b1;
      #1;
      check("d1_in_ready", {63'd0, rdy1}, 64'd1);
      step();
      in_valid = 1'b0;
      check("d1_ov", {63'd0, ov1}, 64'd1);
      check("d1_od", od1, 64'h0000_3000_2402_0001);

      // DEPTH=3 back-to-back stream 1..5
      do_reset();
      out_ready = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         in_valid = (c <= 5);
         in_data  = 64'(c);
         step();
         if (c < 3 || c > 7) begin
            check("d3_stream_idle", {63'd0, ov3}, 64'd0);
         end else begin
            check("d3_stream_ov", {63'd0, ov3}, 64'd1);
            check("d3_stream_od", od3, 64'(c - 2));
         end
      end
      in_valid = 1'b0;

      // DEPTH=2 fill with out_ready=0, then drain
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hA; step();
      in_data = 64'hB; step();
      check("d2_full_ov", {63'd0, ov2}, 64'd1);
      check("d2_full_od", od2, 64'hA);
      in_data = 64'hC;
      #1;
      check("d2_full_rdy", {63'd0, rdy2}, 64'd0);
      step();
      check("d2_hold_od", od2, 64'hA);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("d2_drain_rdy", {63'd0, rdy2}, 64'd1);
      step();
      check("d2_second_ov", {63'd0, ov2}, 64'd1);
      check("d2_second_od", od2, 64'hB);
      step();
      check("d2_empty_ov", {63'd0, ov2}, 64'd0);

      // DEPTH=3 bubble squeeze with out_ready=0
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'h11; step();
      in_valid = 1'b0; step();
      step();
      in_valid = 1'b1; in_data = 64'h22; step();
      in_valid = 1'b0;
      #1;
      check("d3_bubble_rdy", {63'd0, rdy3}, 64'd1);
      check("d3_bubble_od", od3, 64'h11);
      step();
      check("d3_squeeze_hold", od3, 64'h11);
      out_ready = 1'b1;
      step();
      check("d3_squeeze_ov", {63'd0, ov3}, 64'd1);
      check("d3_squeeze_od", od3, 64'h22);

      // DEPTH=3 stall with en=0 for 4 cycles
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 64'd1; step();
      in_data = 64'd2; step();
      in_data = 64'd3; step();
      check("stall_pre_od", od3, 64'd1);
`ifdef PIPE_REG_PERF_EN
      sc_base = sc3;
`endif
      en = 1'b0; in_data = 64'd4;
      #1;
      check("stall_rdy", {63'd0, rdy3}, 64'd0);
      for (int c = 0; c < 4; c++) begin
         step();
         check("stall_ov", {63'd0, ov3}, 64'd1);
         check("stall_od", od3, 64'd1);
      end
`ifdef PIPE_REG_PERF_EN
      check("stall_cnt", {32'd0, sc3 - sc_base}, 64'd4);
`endif
      en = 1'b1;
      step();
      check("stall_resume_od", od3, 64'd2);

      // DEPTH=3 flush of a full pipe, then reset mid-stream
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 64'd1; step();
      in_data = 64'd2; step();
      in_data = 64'd3; step();
      check("flush_full_ov", {63'd0, ov3}, 64'd1);
      in_data = 64'd4;
      #1;
      check("flush_full_rdy", {63'd0, rdy3}, 64'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_ov3", {63'd0, ov3}, 64'd0);
      check("flush_od3_hold", od3, 64'd1);
      check("flush_ov2", {63'd0, ov2}, 64'd0);
`ifdef PIPE_REG_PERF_EN
      check("flush_cnt", {32'd0, fc3}, 64'd1);
`endif
      out_ready = 1'b1;
      in_data = 64'd5; step();
      in_data = 64'd6; step();
      in_data = 64'd7; step();
      check("restream_od", od3, 64'd5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_ov", {63'd0, ov3}, 64'd0);
      check("midrst_od", od3, 64'd0);
      in_data = 64'd8;
      #1;
      check("post_rst_rdy", {63'd0, rdy3}, 64'd1);
      step();
      in_valid = 1'b0;
      check("post_rst_d1_od", od1, 64'd8);
      check("post_rst_d3_ov", {63'd0, ov3}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 64, payload bit width (e.g. {PC, Instr}); legal 1..256.
REQ-002 Parameter DEPTH, default 1, number of register stages; legal 1..4.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  global advance enable; 0 freezes all stages (stall).
REQ-006 Port flush  input  1  discard all in-flight entries.
REQ-007 Port in_valid  input  1  upstream entry present.
REQ-008 Port in_data  input  WIDTH  upstream payload.
REQ-009 Port in_ready  output  1  pipe accepts in_data this cycle.
REQ-010 Port out_valid  output  1  last stage holds a valid entry.
REQ-011 Port out_data  output  WIDTH  last-stage payload.
REQ-012 Port out_ready  input  1  downstream consumes the last stage this cycle.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold a valid bit v[k] and a payload d[k]; stage DEPTH-1 drives out_valid/out_data directly from registers.
REQ-014 Stage move condition SHALL be mv[DEPTH-1] = en & (out_ready | !v[DEPTH-1]); mv[k] = en & (!v[k] | mv[k+1]) for k < DEPTH-1.
REQ-015 in_ready SHALL equal mv[0], combinationally; transfer in occurs when in_valid & in_ready.
REQ-016 On mv[0]: v[0] <= in_valid, d[0] <= in_data when in_valid, else d[0] holds.
REQ-017 On mv[k], k>0: v[k] <= v[k-1], d[k] <= d[k-1] when v[k-1], else d[k] holds (bubble propagates, payload not cleared).
REQ-018 A stage without mv SHALL hold v and d unchanged.
REQ-019 Latency SHALL be DEPTH cycles from accepted input to out_valid with en=1, out_ready=1; throughput 1 entry/cycle.
REQ-020 Full pipe (all v=1) with out_ready=0: in_ready=0, nothing moves, no entry lost or duplicated.
REQ-021 Bubbles SHALL be squeezed: a valid stage SHALL advance into an invalid successor even when out_ready=0.
REQ-022 en=0 SHALL force in_ready=0 and hold all state regardless of out_ready and in_valid.
REQ-023 flush=1 SHALL clear every v[k] on the next edge; d[k] SHALL hold; in_ready SHALL still follow REQ-015 but the accepted input is discarded.
REQ-024 Priority SHALL be reset > flush > en/handshake.
REQ-025 out_valid=1 with out_ready=1 and flush=1 in the same cycle: the entry counts as consumed and the pipe is empty afterwards.

Reset
REQ-026 reset=1 SHALL set all v[k]=0 and all d[k]=0 at the next rising clk edge; out_valid=0, out_data=0 afterwards.
REQ-027 Reset asserted mid-stream SHALL discard all entries with no partial update; first accept allowed the cycle after reset deasserts.

Configuration
REQ-028 Macro PIPE_REG_PERF_EN SHALL, when defined, add outputs stall_cnt (32, counts cycles with out_valid & !out_ready, or en=0) and flush_cnt (32, counts cycles with flush=1), both reset to 0 and wrapping modulo 2^32.
REQ-029 Without PIPE_REG_PERF_EN the counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-030 DEPTH=1: reset, then in_data=0x0000_3000_2402_0001 valid, out_ready=1 -> out_valid=1, out_data=that value after 1 cycle.
REQ-031 DEPTH=3: stream 5 entries 1..5 back-to-back, out_ready=1 -> outputs 1..5 on consecutive cycles, first 3 cycles after first accept.
REQ-032 DEPTH=2: fill with 0xA, 0xB, out_ready=0 -> in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB delivered, no loss.
REQ-033 DEPTH=3: entries at stages 0 and 2 only, out_ready=0 -> next cycle stage-0 entry moves to stage 1; in_ready=1.
REQ-034 en=0 for 4 cycles mid-stream -> all outputs frozen, in_ready=0; with PIPE_REG_PERF_EN stall_cnt increments by 4.
REQ-035 flush=1 with pipe full, then reset=1 mid-stream -> flush empties all valids next cycle; reset drives out_data=0, out_valid=0.
